tl_ul_reg_host: RTL and testbench

Single-outstanding TL-UL initiator that drives the producer side of `TL_UL_8_32_8_32`. It converts a simple valid/ready register command port into TL-UL Get, PutFullData and PutPartialData requests, and returns the responses on a valid/ready response port. It sits between a control source (test sequencer or CSR bridge) and responder-side blocks such as adders with register ports. It adds source-ID tagging, stale-response discard and a response timeout.

---
 rtl/tl_ul_reg_host_if.sv | 29 ++
 rtl/tl_ul_reg_host.sv | 223 ++++++++++++++++++++++
 tb/tb_tl_ul_reg_host.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_ul_reg_host_if.sv
// TL-UL link with 8-bit source, 32-bit address and 32-bit data.
// producer drives the A channel and d_ready; consumer is the responder side.
interface TL_UL_8_32_8_32;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [7:0]  d_source;
  logic [31:0] d_data;
  logic        d_error;

  modport producer (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_source, d_data, d_error
  );

  modport consumer (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_source, d_data, d_error
  );
endinterface

// File: rtl/tl_ul_reg_host.sv
// Single-outstanding TL-UL initiator: valid/ready register commands in, TL-UL A/D out,
// with source tagging, stale D-beat discard and a response timeout.
module tl_ul_reg_host #(
  parameter int unsigned TIMEOUT     = 32'd256,
  parameter logic [7:0]  SOURCE_INIT = 8'd0
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [31:0]             cmd_addr,
  input  logic [31:0]             cmd_wdata,
  input  logic [3:0]              cmd_mask,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic [7:0]              stale_drops,
  TL_UL_8_32_8_32.producer        bus
);

  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e      state_r;
  state_e      state_nx_s;

  logic [2:0]  a_opcode_r;
  logic [31:0] a_address_r;
  logic [3:0]  a_mask_r;
  logic [31:0] a_data_r;
  logic [7:0]  a_source_r;
  logic [1:0]  a_size_r;
  logic        is_read_r;
  logic [7:0]  src_cnt_r;
  logic [31:0] tmo_cnt_r;

  logic [31:0] rsp_rdata_r;
  logic        rsp_error_r;
  logic        rsp_timeout_r;
  logic [7:0]  stale_r;

  logic        d_beat_s;
  logic        d_hit_s;
  logic        d_stale_s;
  logic        tmo_hit_s;
  logic        cmd_take_s;
  logic        a_fire_s;

  // A read expects AccessAckData, a write expects AccessAck; anything else is an error.
  function automatic logic rsp_err_f(input logic is_read, input logic [2:0] d_opcode,
                                     input logic d_error);
    logic op_bad;
    if (is_read) begin
      op_bad = (d_opcode != OP_ACK_DATA);
    end else begin
      op_bad = (d_opcode != OP_ACK);
    end
    return d_error | op_bad;
  endfunction

  // Handshake and D-beat classification
  always_comb begin
    cmd_take_s = (state_r == ST_IDLE) && cmd_valid;
    a_fire_s   = (state_r == ST_REQ) && bus.a_ready;
    d_beat_s   = (state_r == ST_WAIT) && bus.d_valid;
    d_hit_s    = d_beat_s && (bus.d_source == a_source_r);
    d_stale_s  = d_beat_s && (bus.d_source != a_source_r);
    if (TIMEOUT != 32'd0) begin
      tmo_hit_s = (state_r == ST_WAIT) && (tmo_cnt_r == TIMEOUT);
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Next-state logic; a matching beat takes priority over the timeout
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nx_s = ST_REQ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.a_ready) begin
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (d_hit_s || tmo_hit_s) begin
          state_nx_s = ST_RESP;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // A-channel fields, latched at command acceptance and held through REQ
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_opcode_r  <= 3'd0;
      a_address_r <= 32'd0;
      a_mask_r    <= 4'd0;
      a_data_r    <= 32'd0;
      a_source_r  <= 8'd0;
      a_size_r    <= 2'd0;
      is_read_r   <= 1'b0;
    end else if (cmd_take_s) begin
      if (!cmd_write) begin
        a_opcode_r <= OP_GET;
      end else if (cmd_mask == 4'hF) begin
        a_opcode_r <= OP_PUT_FULL;
      end else begin
        a_opcode_r <= OP_PUT_PART;
      end
      a_address_r <= {cmd_addr[31:2], 2'b00};
      a_mask_r    <= cmd_write ? cmd_mask : 4'hF;
      a_data_r    <= cmd_write ? cmd_wdata : 32'd0;
      a_source_r  <= src_cnt_r;
      a_size_r    <= 2'd2;
      is_read_r   <= !cmd_write;
    end
  end

  // Source counter advances once per issued request, wrapping at 256
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      src_cnt_r <= SOURCE_INIT;
    end else if (a_fire_s) begin
      src_cnt_r <= src_cnt_r + 8'd1;
    end
  end

  // Timeout counter: cleared on WAIT entry, counts WAIT cycles without a matching beat
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tmo_cnt_r <= 32'd0;
    end else if (a_fire_s) begin
      tmo_cnt_r <= 32'd0;
    end else if ((state_r == ST_WAIT) && !d_hit_s && (TIMEOUT != 32'd0) && !tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end
  end

  // Response capture from the matching beat or the timeout
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rsp_rdata_r   <= 32'd0;
      rsp_error_r   <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else if (d_hit_s) begin
      rsp_error_r   <= rsp_err_f(is_read_r, bus.d_opcode, bus.d_error);
      rsp_timeout_r <= 1'b0;
      rsp_rdata_r   <= (is_read_r && (bus.d_opcode == OP_ACK_DATA)) ? bus.d_data : 32'd0;
    end else if (tmo_hit_s) begin
      rsp_error_r   <= 1'b1;
      rsp_timeout_r <= 1'b1;
      rsp_rdata_r   <= 32'd0;
    end
  end

  // Saturating count of discarded beats carrying a foreign source
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stale_r <= 8'd0;
    end else if (d_stale_s && (stale_r != 8'hFF)) begin
      stale_r <= stale_r + 8'd1;
    end
  end

  assign cmd_ready     = (state_r == ST_IDLE);
  assign rsp_valid     = (state_r == ST_RESP);
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_error     = rsp_error_r;
  assign rsp_timeout   = rsp_timeout_r;
  assign stale_drops   = stale_r;

  assign bus.a_valid   = (state_r == ST_REQ);
  assign bus.d_ready   = (state_r == ST_WAIT);
  assign bus.a_opcode  = a_opcode_r;
  assign bus.a_param   = 3'd0;
  assign bus.a_size    = a_size_r;
  assign bus.a_source  = a_source_r;
  assign bus.a_address = a_address_r;
  assign bus.a_mask    = a_mask_r;
  assign bus.a_data    = a_data_r;

endmodule

// File: tb/tb_tl_ul_reg_host.sv
// Self-checking bench for tl_ul_reg_host: directed vector table, hand-written
// timeout/stale and reset sequences, then randomized transactions against a reference model.
module tb_tl_ul_reg_host;
  localparam int TMO = 8;

  logic        clk;
  logic        rst_b;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [7:0]  stale_drops;

  TL_UL_8_32_8_32 bus_if ();

  tl_ul_reg_host #(.TIMEOUT(TMO), .SOURCE_INIT(8'd0)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_mask    (cmd_mask),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .rsp_timeout (rsp_timeout),
    .stale_drops (stale_drops),
    .bus         (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int src_m = 0;
  int stale_m = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          a_dly;
    int          n_stale;
    int          d_dly;
    logic [2:0]  d_op;
    logic        d_err;
    logic [31:0] d_dat;
    int          r_dly;
    logic [2:0]  e_op;
    logic [31:0] e_addr;
    logic [3:0]  e_mask;
    logic [31:0] e_adata;
    logic        e_err;
    logic        e_tmo;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctrl();
    return {28'd0, cmd_ready, bus_if.a_valid, bus_if.d_ready, rsp_valid};
  endfunction

  // One full transaction starting and ending at a negedge in IDLE.
  // stale_src < 0 picks a random foreign source for the stale beats.
  task automatic run_txn(
      input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask,
      input int a_dly, input int n_stale, input int stale_src, input int d_dly,
      input logic [2:0] d_op, input logic d_err, input logic [31:0] d_dat, input int r_dly,
      input logic [2:0] e_op, input logic [31:0] e_addr, input logic [3:0] e_mask,
      input logic [31:0] e_adata, input logic e_err, input logic e_tmo, input logic [31:0] e_rdata);
    logic [7:0] isrc;
    int k;
    int end_idx;
    logic stale_now;
    isrc = 8'(src_m);
    k = n_stale + d_dly;
    end_idx = e_tmo ? TMO : k;
    check("idle_ctrl", ctrl(), 32'h8);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_mask = mask;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_mask = ~mask;
    for (int i = 0; i <= a_dly; i++) begin
      check("req_ctrl", ctrl(), 32'h4);
      check("a_opcode", 32'(bus_if.a_opcode), 32'(e_op));
      check("a_address", bus_if.a_address, e_addr);
      check("a_mask", 32'(bus_if.a_mask), 32'(e_mask));
      check("a_data", bus_if.a_data, e_adata);
      check("a_source", 32'(bus_if.a_source), 32'(isrc));
      check("a_size", 32'(bus_if.a_size), 32'd2);
      bus_if.a_ready = (i == a_dly);
      @(negedge clk);
    end
    bus_if.a_ready = 1'b0;
    src_m = (src_m + 1) % 256;
    for (int c = 0; c <= end_idx; c++) begin
      check("wait_ctrl", ctrl(), 32'h2);
      stale_now = (c < n_stale);
      if (stale_now) begin
        bus_if.d_valid  = 1'b1;
        bus_if.d_source = (stale_src >= 0) ? 8'(stale_src)
                                           : isrc + 8'($urandom_range(1, 255));
        bus_if.d_opcode = 3'($urandom);
        bus_if.d_error  = 1'($urandom);
        bus_if.d_data   = $urandom;
      end else if (!e_tmo && c == k) begin
        bus_if.d_valid  = 1'b1;
        bus_if.d_source = isrc;
        bus_if.d_opcode = d_op;
        bus_if.d_error  = d_err;
        bus_if.d_data   = d_dat;
      end else begin
        bus_if.d_valid  = 1'b0;
        bus_if.d_source = isrc;
        bus_if.d_data   = $urandom;
      end
      @(negedge clk);
      if (stale_now && stale_m < 255) stale_m++;
    end
    bus_if.d_valid = 1'b0;
    check("stale_drops", 32'(stale_drops), 32'(stale_m));
    for (int i = 0; i <= r_dly; i++) begin
      check("resp_ctrl", ctrl(), 32'h1);
      check("rsp_error", 32'(rsp_error), 32'(e_err));
      check("rsp_timeout", 32'(rsp_timeout), 32'(e_tmo));
      check("rsp_rdata", rsp_rdata, e_rdata);
      rsp_ready = (i == r_dly);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check("post_resp_ctrl", ctrl(), 32'h8);
  endtask

  task automatic run_vec(input vec_t v);
    run_txn(v.wr, v.addr, v.wdata, v.mask, v.a_dly, v.n_stale, -1, v.d_dly, v.d_op, v.d_err,
            v.d_dat, v.r_dly, v.e_op, v.e_addr, v.e_mask, v.e_adata, v.e_err, v.e_tmo, v.e_rdata);
  endtask

  // Reference model: builds expectations from the command and responder behaviour
  task automatic run_random(input int n);
    logic        wr;
    logic [31:0] addr, wdata, d_dat;
    logic [3:0]  mask;
    logic [2:0]  d_op;
    logic        d_err, tmo;
    int          n_st, d_dly;
    for (int t = 0; t < n; t++) begin
      wr    = 1'($urandom);
      addr  = $urandom;
      wdata = $urandom;
      mask  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      n_st  = $urandom_range(0, 3) == 0 ? 1 : 0;
      d_dly = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 2);
      tmo   = (n_st + d_dly) > TMO;
      d_op  = ($urandom_range(0, 4) == 0) ? 3'($urandom) : (wr ? 3'd0 : 3'd1);
      d_err = ($urandom_range(0, 9) == 0);
      d_dat = $urandom;
      run_txn(wr, addr, wdata, mask, $urandom_range(0, 2), n_st, -1, d_dly, d_op, d_err, d_dat,
              $urandom_range(0, 2),
              wr ? ((mask == 4'hF) ? 3'd0 : 3'd1) : 3'd4,
              addr & 32'hFFFF_FFFC,
              wr ? mask : 4'hF,
              wr ? wdata : 32'd0,
              tmo || d_err || (wr ? (d_op != 3'd0) : (d_op != 3'd1)),
              tmo,
              (!tmo && !wr && d_op == 3'd1) ? d_dat : 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] late_src;
    //         wr    addr          wdata         mask  a  st d  dop   de    ddat          r  eop   eaddr         emask eadata        eerr  etmo  erdata
    vecs[0] = '{1'b0, 32'h0000_0104, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 3'd1, 1'b0, 32'hDEAD_BEEF, 0, 3'd4, 32'h0000_0104, 4'hF, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF, 0, 0, 0, 3'd0, 1'b0, 32'h5555_5555, 0, 3'd0, 32'h0000_0010, 4'hF, 32'h1122_3344, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'h3, 0, 0, 0, 3'd0, 1'b0, 32'h6666_6666, 0, 3'd1, 32'h0000_0010, 4'h3, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0200, 32'h0,         4'h0, 5, 0, 2, 3'd1, 1'b0, 32'h1234_5678, 3, 3'd4, 32'h0000_0200, 4'hF, 32'h0,         1'b0, 1'b0, 32'h1234_5678};
    vecs[4] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 0, 3'd1, 1'b1, 32'hCAFE_F00D, 0, 3'd4, 32'h0000_0008, 4'hF, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 0, 0, 1, 3'd0, 1'b0, 32'h7777_7777, 0, 3'd4, 32'h0000_000C, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 4'hF, 1, 0, 0, 3'd1, 1'b0, 32'h8888_8888, 1, 3'd0, 32'h0000_0020, 4'hF, 32'h0BAD_CAFE, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0107, 32'h0,         4'h0, 0, 2, 1, 3'd1, 1'b0, 32'h0BAD_F00D, 0, 3'd4, 32'h0000_0104, 4'hF, 32'h0,         1'b0, 1'b0, 32'h0BAD_F00D};
    vecs[8] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 8, 3'd1, 1'b0, 32'h0000_0008, 0, 3'd4, 32'h0000_0040, 4'hF, 32'h0,         1'b0, 1'b0, 32'h0000_0008};
    vecs[9] = '{1'b1, 32'h0000_0046, 32'h0102_0304, 4'h5, 0, 0, 0, 3'd0, 1'b0, 32'h0,         1, 3'd1, 32'h0000_0044, 4'h5, 32'h0102_0304, 1'b1, 1'b1, 32'h0};

    rst_b = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0; cmd_mask = 4'd0;
    rsp_ready = 1'b0;
    bus_if.a_ready = 1'b0; bus_if.d_valid = 1'b0; bus_if.d_opcode = 3'd0;
    bus_if.d_source = 8'd0; bus_if.d_data = 32'd0; bus_if.d_error = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_valid", 32'(bus_if.a_valid), 32'd0);
    check("rst_d_ready", 32'(bus_if.d_ready), 32'd0);
    check("rst_a_fields", {bus_if.a_opcode, bus_if.a_size, bus_if.a_source, bus_if.a_mask}, 32'd0);
    check("rst_a_address", bus_if.a_address, 32'd0);
    check("rst_a_data", bus_if.a_data, 32'd0);
    check("rst_rsp", {29'd0, rsp_valid, rsp_error, rsp_timeout}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_stale", 32'(stale_drops), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", ctrl(), 32'h8);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Late answer to the timed-out request stalls on the bus, then is dropped as stale
    late_src = 8'(src_m - 1);
    bus_if.d_valid = 1'b1; bus_if.d_source = late_src; bus_if.d_opcode = 3'd0;
    bus_if.d_data = 32'h0; bus_if.d_error = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("late_stall_ctrl", ctrl(), 32'h8);
      check("late_stall_stale", 32'(stale_drops), 32'(stale_m));
    end
    run_txn(1'b0, 32'h0000_0050, 32'h0, 4'h0, 2, 1, int'(late_src), 0, 3'd1, 1'b0,
            32'h600D_D00D, 0, 3'd4, 32'h0000_0050, 4'hF, 32'h0, 1'b0, 1'b0, 32'h600D_D00D);

    run_random(270);

    // Reset in the middle of WAIT aborts with no response
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0300;
    @(negedge clk);
    cmd_valid = 1'b0; bus_if.a_ready = 1'b1;
    @(negedge clk);
    bus_if.a_ready = 1'b0;
    check("pre_rst_wait", ctrl(), 32'h2);
    #2 rst_b = 1'b0;
    #1;
    check("async_rst_ctrl", {30'd0, bus_if.a_valid, bus_if.d_ready}, 32'd0);
    check("async_rst_src", 32'(bus_if.a_source), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    src_m = 0;
    stale_m = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_ctrl", ctrl(), 32'h8);
      check("post_rst_stale", 32'(stale_drops), 32'd0);
    end
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, -1, 0, 3'd1, 1'b0, 32'h0000_ABCD, 0,
            3'd4, 32'h0000_0010, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0000_ABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
